// File: rtl/alu_issue.sv
// Purpose : execute-stage front end; decodes RV32I/M OP/OP-IMM into ALU op_mode/func_op, drives operands, tracks rd to writeback.
// Latency : accept at edge N, ALU sees operands after N, result/o_wb_valid after N+1 for single-cycle ops; MUL/DIV/MOD wait on i_alu_stall.
// Backpr. : writeback stalls freeze the ALU via o_alu_hold; EX holds and o_ready drops while EX is full and cannot advance.
// Ports   : decode side (i_valid/o_ready, opcode, funct3/7, rs1/rs2/imm, rd), ALU side (o_op_mode, o_func_op, o_a, o_b,
//           o_alu_hold, i_alu_stall, i_alu_result), writeback side (o_wb_valid/i_wb_ready, o_wb_rd, o_wb_data), o_illegal pulse.
module alu_issue #(
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic [6:0]       i_funct7,
    input  logic [31:0]      i_rs1_data,
    input  logic [31:0]      i_rs2_data,
    input  logic [31:0]      i_imm,
    input  logic [TAG_W-1:0] i_rd,
    output logic [2:0]       o_op_mode,
    output logic [2:0]       o_func_op,
    output logic [31:0]      o_a,
    output logic [31:0]      o_b,
    output logic             o_alu_hold,
    input  logic             i_alu_stall,
    input  logic [31:0]      i_alu_result,
    output logic             o_wb_valid,
    input  logic             i_wb_ready,
    output logic [TAG_W-1:0] o_wb_rd,
    output logic [31:0]      o_wb_data,
    output logic             o_illegal
);

    localparam logic [2:0] M_IDLE    = 3'd0;
    localparam logic [2:0] M_LOGIC   = 3'd1;
    localparam logic [2:0] M_SHIFT   = 3'd2;
    localparam logic [2:0] M_COMPARE = 3'd3;
    localparam logic [2:0] M_ADD_SUB = 3'd4;
    localparam logic [2:0] M_MUL     = 3'd5;
    localparam logic [2:0] M_DIV     = 3'd6;
    localparam logic [2:0] M_MOD     = 3'd7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // EX slot
    logic             ex_valid_q, ex_valid_d;
    logic [2:0]       ex_mode_q, ex_mode_d;
    logic [2:0]       ex_func_q, ex_func_d;
    logic [31:0]      ex_a_q, ex_a_d;
    logic [31:0]      ex_b_q, ex_b_d;
    logic [TAG_W-1:0] ex_rd_q, ex_rd_d;
    // WB slot (data lives in the ALU output register)
    logic             wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0] wb_rd_q, wb_rd_d;
    logic             illegal_q, illegal_d;

    logic        is_op, is_imm, f7b5, f7_zero, f7_alt, f7_m;
    logic        dec_legal;
    logic [2:0]  dec_mode, dec_func;
    logic [31:0] dec_b;
    logic        wb_free, ex_mc, present, ex_adv, ready, accept;

    assign is_op   = (i_opcode == OPC_OP);
    assign is_imm  = (i_opcode == OPC_OP_IMM);
    assign f7b5    = i_funct7[5];
    assign f7_zero = (i_funct7 == 7'b0000000);
    assign f7_alt  = (i_funct7 == 7'b0100000);
    assign f7_m    = (i_funct7 == 7'b0000001);

    // For OP-IMM the funct7 field is immediate bits except on shifts, so it only
    // constrains legality for OP and for the immediate shift forms.
    always_comb begin
        dec_legal = 1'b0;
        dec_mode  = M_IDLE;
        dec_func  = 3'd0;
        dec_b     = is_op ? i_rs2_data : i_imm;
        if (is_op && f7_m) begin
            case (i_funct3)
                3'b000:  begin dec_legal = 1'b1; dec_mode = M_MUL; end
                3'b100:  begin dec_legal = 1'b1; dec_mode = M_DIV; end
                3'b110:  begin dec_legal = 1'b1; dec_mode = M_MOD; end
                default: dec_legal = 1'b0;
            endcase
        end else if (is_op || is_imm) begin
            case (i_funct3)
                3'b000: begin
                    dec_legal = is_imm | f7_zero | f7_alt;
                    dec_mode  = M_ADD_SUB;
                    dec_func  = {2'b00, is_op & f7b5};
                end
                3'b001: begin
                    dec_legal = f7_zero;
                    dec_mode  = M_SHIFT;
                    dec_func  = 3'b000;
                end
                3'b101: begin
                    dec_legal = f7_zero | f7_alt;
                    dec_mode  = M_SHIFT;
                    dec_func  = {1'b0, 1'b1, f7b5};
                end
                3'b010: begin
                    dec_legal = is_imm | f7_zero;
                    dec_mode  = M_COMPARE;
                    dec_func  = 3'b000;
                end
                3'b100: begin
                    dec_legal = is_imm | f7_zero;
                    dec_mode  = M_LOGIC;
                    dec_func  = 3'd2;
                end
                3'b110: begin
                    dec_legal = is_imm | f7_zero;
                    dec_mode  = M_LOGIC;
                    dec_func  = 3'd1;
                end
                3'b111: begin
                    dec_legal = is_imm | f7_zero;
                    dec_mode  = M_LOGIC;
                    dec_func  = 3'd0;
                end
                default: dec_legal = 1'b0;   // SLTU/SLTIU
            endcase
            if (is_imm && (i_funct3 == 3'b001 || i_funct3 == 3'b101)) begin
                dec_b = {27'b0, i_imm[4:0]};
            end
        end
    end

    // A multi-cycle op is kept off the ALU until WB is empty, so hold can never
    // mask its completion; this also forces an IDLE cycle between two of them.
    assign wb_free = !wb_valid_q | i_wb_ready;
    assign ex_mc   = (ex_mode_q == M_MUL) || (ex_mode_q == M_DIV) || (ex_mode_q == M_MOD);
    assign present = ex_valid_q & (!ex_mc | !wb_valid_q);
    assign ex_adv  = present & !i_alu_stall & wb_free;
    assign ready   = !ex_valid_q | ex_adv;
    assign accept  = i_valid & ready;

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_mode_d  = ex_mode_q;
        ex_func_d  = ex_func_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_rd_d    = ex_rd_q;
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        illegal_d  = accept & !dec_legal;

        // EX is either empty or draining this edge whenever ready is high.
        if (ready) begin
            ex_valid_d = accept & dec_legal;
        end
        if (accept && dec_legal) begin
            ex_mode_d = dec_mode;
            ex_func_d = dec_func;
            ex_a_d    = i_rs1_data;
            ex_b_d    = dec_b;
            ex_rd_d   = i_rd;
        end

        if (ex_adv) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd_q;
        end else if (wb_valid_q && i_wb_ready) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_valid_q <= 1'b0;
            ex_mode_q  <= M_IDLE;
            ex_func_q  <= 3'd0;
            ex_a_q     <= 32'd0;
            ex_b_q     <= 32'd0;
            ex_rd_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_mode_q  <= ex_mode_d;
            ex_func_q  <= ex_func_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_rd_q    <= ex_rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            illegal_q  <= illegal_d;
        end
    end

    assign o_ready    = ready;
    assign o_op_mode  = present ? ex_mode_q : M_IDLE;
    assign o_func_op  = present ? ex_func_q : 3'd0;
    assign o_a        = present ? ex_a_q : 32'd0;
    assign o_b        = present ? ex_b_q : 32'd0;
    assign o_alu_hold = wb_valid_q & !i_wb_ready;
    assign o_wb_valid = wb_valid_q;
    assign o_wb_rd    = wb_rd_q;
    assign o_wb_data  = i_alu_result;
    assign o_illegal  = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Purpose : randomized + directed bench for alu_issue with a behavioural ALU and an instruction-level reference scoreboard.
// Latency : n/a (testbench).
// Backpr. : drives i_wb_ready low randomly and in a directed burst.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        i_rst, i_valid, o_ready;
    logic [6:0]  i_opcode, i_funct7;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1_data, i_rs2_data, i_imm;
    logic [4:0]  i_rd, o_wb_rd;
    logic [2:0]  o_op_mode, o_func_op;
    logic [31:0] o_a, o_b, i_alu_result, o_wb_data;
    logic        o_alu_hold, i_alu_stall, o_wb_valid, i_wb_ready, o_illegal;

    alu_issue #(.TAG_W(5)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7(i_funct7),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm), .i_rd(i_rd),
        .o_op_mode(o_op_mode), .o_func_op(o_func_op), .o_a(o_a), .o_b(o_b),
        .o_alu_hold(o_alu_hold), .i_alu_stall(i_alu_stall), .i_alu_result(i_alu_result),
        .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_rd(o_wb_rd),
        .o_wb_data(o_wb_data), .o_illegal(o_illegal)
    );

    initial forever #5 clk = ~clk;

    localparam logic [6:0] OP = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- arithmetic helpers (RISC-V semantics) ----------------
    function automatic logic [31:0] sdiv(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a; sb = b;
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
    endfunction

    function automatic logic [31:0] srem(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a; sb = b;
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
    endfunction

    function automatic logic [31:0] slt(input logic [31:0] a, input logic [31:0] b);
        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endfunction

    // ---------------- instruction-level reference ----------------
    task automatic ref_exec(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                            output logic legal, output logic [31:0] res);
        legal = 1'b1;
        res   = 32'd0;
        if (opc == OP && f7 == 7'h00) begin
            case (f3)
                3'd0: res = a + b;
                3'd1: res = a << b[4:0];
                3'd2: res = slt(a, b);
                3'd4: res = a ^ b;
                3'd5: res = a >> b[4:0];
                3'd6: res = a | b;
                3'd7: res = a & b;
                default: legal = 1'b0;
            endcase
        end else if (opc == OP && f7 == 7'h20) begin
            case (f3)
                3'd0: res = a - b;
                3'd5: res = 32'($signed(a) >>> b[4:0]);
                default: legal = 1'b0;
            endcase
        end else if (opc == OP && f7 == 7'h01) begin
            case (f3)
                3'd0: res = a * b;
                3'd4: res = sdiv(a, b);
                3'd6: res = srem(a, b);
                default: legal = 1'b0;
            endcase
        end else if (opc == OPI) begin
            case (f3)
                3'd0: res = a + imm;
                3'd1: if (f7 == 7'h00) res = a << imm[4:0]; else legal = 1'b0;
                3'd2: res = slt(a, imm);
                3'd4: res = a ^ imm;
                3'd5: if (f7 == 7'h00) res = a >> imm[4:0];
                      else if (f7 == 7'h20) res = 32'($signed(a) >>> imm[4:0]);
                      else legal = 1'b0;
                3'd6: res = a | imm;
                3'd7: res = a & imm;
                default: legal = 1'b0;
            endcase
        end else begin
            legal = 1'b0;
        end
    endtask

    // ---------------- behavioural ALU (registered result, multi-cycle MUL/DIV/MOD) ----------------
    function automatic logic [31:0] alu_fn(input logic [2:0] m, input logic [2:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
        case (m)
            3'd1: return (f == 3'd0) ? (a & b) : (f == 3'd1) ? (a | b) : (a ^ b);
            3'd2: return (f == 3'd0) ? (a << b[4:0]) : (f == 3'd2) ? (a >> b[4:0])
                                     : 32'($signed(a) >>> b[4:0]);
            3'd3: return slt(a, b);
            3'd4: return f[0] ? (a - b) : (a + b);
            3'd5: return a * b;
            3'd6: return sdiv(a, b);
            3'd7: return srem(a, b);
            default: return 32'd0;
        endcase
    endfunction

    logic [2:0]  alu_prev_q;
    logic [31:0] alu_res_q, mc_a_q, mc_b_q;
    int          alu_cnt_q, alu_lat_q;
    logic        mc_now, mc_start;

    // The unit restarts only on a mode edge and computes from operands latched at start.
    assign mc_now      = (o_op_mode >= 3'd5);
    assign mc_start    = mc_now && (alu_prev_q != o_op_mode);
    assign i_alu_stall = mc_now && (mc_start || alu_cnt_q < alu_lat_q);
    assign i_alu_result = alu_res_q;

    always @(posedge clk) begin
        if (i_rst) begin
            alu_prev_q <= 3'd0;
            alu_res_q  <= 32'd0;
            alu_cnt_q  <= 0;
            alu_lat_q  <= 0;
            mc_a_q     <= 32'd0;
            mc_b_q     <= 32'd0;
        end else if (!o_alu_hold) begin
            alu_prev_q <= o_op_mode;
            if (mc_start) begin
                mc_a_q    <= o_a;
                mc_b_q    <= o_b;
                alu_cnt_q <= 1;
                alu_lat_q <= int'($urandom_range(1, 4));
            end else if (mc_now) begin
                alu_cnt_q <= alu_cnt_q + 1;
            end
            if (!mc_now) alu_res_q <= alu_fn(o_op_mode, o_func_op, o_a, o_b);
            else if (!i_alu_stall) alu_res_q <= alu_fn(o_op_mode, o_func_op, mc_a_q, mc_b_q);
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [4:0]  exp_rd[$];
    logic [31:0] exp_data[$];
    logic        exp_illegal = 1'b0;
    int          illegal_seen = 0, beats = 0, mc_starts = 0;
    logic        rand_bp = 1'b0;

    initial begin : monitor
        logic prev_stall;
        logic [4:0] prev_rd;
        logic [31:0] prev_data;
        logic [2:0] prev_mode;
        prev_stall = 1'b0; prev_rd = '0; prev_data = '0; prev_mode = 3'd0;
        forever begin
            @(negedge clk);
            if (i_rst) begin
                prev_stall = 1'b0;
                prev_mode  = 3'd0;
                continue;
            end
            check_val("illegal_pulse", 32'(o_illegal), 32'(exp_illegal));
            if (o_illegal) illegal_seen++;
            exp_illegal = 1'b0;
            if (i_wb_ready) check_val("hold_with_ready", 32'(o_alu_hold), 32'd0);
            if (i_alu_stall) check_val("ready_in_stall", 32'(o_ready), 32'd0);
            if (prev_stall) begin
                check_val("bp_valid_stable", 32'(o_wb_valid), 32'd1);
                check_val("bp_rd_stable", 32'(o_wb_rd), 32'(prev_rd));
                check_val("bp_data_stable", o_wb_data, prev_data);
            end
            if (o_wb_valid && i_wb_ready) begin
                if (exp_rd.size() == 0) begin
                    check_val("spurious_beat", 32'(o_wb_valid), 32'd0);
                end else begin
                    check_val("wb_rd", 32'(o_wb_rd), 32'(exp_rd.pop_front()));
                    check_val("wb_data", o_wb_data, exp_data.pop_front());
                    beats++;
                end
            end
            prev_stall = o_wb_valid & !i_wb_ready;
            prev_rd    = o_wb_rd;
            prev_data  = o_wb_data;
            if (o_op_mode >= 3'd5 && prev_mode < 3'd5) mc_starts++;
            prev_mode = o_op_mode;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_bp) i_wb_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [4:0] rd);
        logic leg;
        logic [31:0] r;
        int waited;
        ref_exec(opc, f3, f7, a, b, imm, leg, r);
        i_valid = 1'b1; i_opcode = opc; i_funct3 = f3; i_funct7 = f7;
        i_rs1_data = a; i_rs2_data = b; i_imm = imm; i_rd = rd;
        waited = 0;
        @(negedge clk);
        while (!o_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!o_ready) begin
            check_val("accept_timeout", 32'(o_ready), 32'd1);
            i_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (leg) begin
            exp_rd.push_back(rd);
            exp_data.push_back(r);
        end
        exp_illegal = !leg;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_rd.size() != 0 || o_wb_valid) && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_val("drain_left", 32'(exp_rd.size()), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'($urandom_range(0, 15));
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_instr();
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [11:0] t12;
        logic [31:0] imm;
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 9) opc = OP;
        else if (r < 18) opc = OPI;
        else if (r == 18) opc = 7'b0000011;
        else opc = 7'($urandom);
        f3  = 3'($urandom_range(0, 7));
        t12 = 12'($urandom);
        if (opc == OPI && (f3 == 3'd1 || f3 == 3'd5) && $urandom_range(0, 3) != 0)
            t12[11:5] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        imm = {{20{t12[11]}}, t12};
        if (opc == OPI) f7 = imm[11:5];
        else begin
            r = int'($urandom_range(0, 7));
            f7 = (r < 3) ? 7'h00 : (r < 5) ? 7'h20 : (r < 7) ? 7'h01 : 7'($urandom);
        end
        issue(opc, f3, f7, pick(), pick(), imm, 5'($urandom));
    endtask

    initial begin : stimulus
        int b0, il0, mc0, waited;
        i_rst = 1'b1; i_valid = 1'b0; i_opcode = '0; i_funct3 = '0; i_funct7 = '0;
        i_rs1_data = '0; i_rs2_data = '0; i_imm = '0; i_rd = '0; i_wb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        check_val("rst_wb_valid", 32'(o_wb_valid), 32'd0);
        check_val("rst_op_mode", 32'(o_op_mode), 32'd0);
        check_val("rst_illegal", 32'(o_illegal), 32'd0);
        check_val("rst_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;

        // ADD 5+7 -> rd 3
        issue(OP, 3'd0, 7'h00, 32'd5, 32'd7, 32'd0, 5'd3);
        @(negedge clk);
        check_val("add_mode", 32'(o_op_mode), 32'd4);
        check_val("add_func", 32'(o_func_op), 32'd0);
        check_val("add_a", o_a, 32'd5);
        check_val("add_b", o_b, 32'd7);
        @(negedge clk);
        check_val("add_wb_valid", 32'(o_wb_valid), 32'd1);
        check_val("add_wb_rd", 32'(o_wb_rd), 32'd3);
        check_val("add_wb_data", o_wb_data, 32'd12);
        @(posedge clk); #1;
        drain();

        // SRAI 0x80000000 >>> 4
        issue(OPI, 3'd5, 7'h20, 32'h8000_0000, 32'd0, 32'h0000_0404, 5'd4);
        @(negedge clk);
        check_val("srai_mode", 32'(o_op_mode), 32'd2);
        check_val("srai_func", 32'(o_func_op), 32'd3);
        check_val("srai_b", o_b, 32'd4);
        @(negedge clk);
        check_val("srai_wb_data", o_wb_data, 32'hF800_0000);
        @(posedge clk); #1;
        drain();

        // back-to-back MUL
        mc0 = mc_starts; b0 = beats;
        issue(OP, 3'd0, 7'h01, 32'd6, 32'd7, 32'd0, 5'd5);
        issue(OP, 3'd0, 7'h01, 32'd3, 32'd3, 32'd0, 5'd6);
        drain();
        check_val("mul_issues", 32'(mc_starts - mc0), 32'd2);
        check_val("mul_beats", 32'(beats - b0), 32'd2);

        // back-pressure with a stream of 4 ADDs
        b0 = beats;
        i_wb_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    issue(OP, 3'd0, 7'h00, 32'(k + 1), 32'(10 * k), 32'd0, 5'(10 + k));
            end
            begin
                waited = 0;
                @(negedge clk);
                while (!o_wb_valid && waited < 50) begin @(negedge clk); waited++; end
                check_val("bp_first_beat", 32'(o_wb_valid), 32'd1);
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    check_val("bp_hold", 32'(o_alu_hold), 32'd1);
                end
                check_val("bp_ready_low", 32'(o_ready), 32'd0);
                @(posedge clk); #1;
                i_wb_ready = 1'b1;
            end
        join
        drain();
        check_val("bp_beats", 32'(beats - b0), 32'd4);

        // illegal instructions
        il0 = illegal_seen; b0 = beats;
        issue(OP, 3'd5, 7'h01, 32'd9, 32'd2, 32'd0, 5'd1);
        issue(7'b0000011, 3'd0, 7'h00, 32'd9, 32'd2, 32'd0, 5'd2);
        issue(OP, 3'd0, 7'h00, 32'd20, 32'd22, 32'd0, 5'd9);
        drain();
        check_val("illegal_pulses", 32'(illegal_seen - il0), 32'd2);
        check_val("illegal_beats", 32'(beats - b0), 32'd1);

        // reset during a DIV
        issue(OP, 3'd4, 7'h01, 32'd100, 32'd7, 32'd0, 5'd8);
        waited = 0;
        @(negedge clk);
        while (o_op_mode != 3'd6 && waited < 20) begin @(negedge clk); waited++; end
        check_val("div_presented", 32'(o_op_mode), 32'd6);
        @(posedge clk); #1;
        i_rst = 1'b1;
        exp_rd.delete(); exp_data.delete(); exp_illegal = 1'b0;
        @(posedge clk); #1;
        i_rst = 1'b0;
        @(negedge clk);
        check_val("mrst_wb_valid", 32'(o_wb_valid), 32'd0);
        check_val("mrst_op_mode", 32'(o_op_mode), 32'd0);
        check_val("mrst_a", o_a, 32'd0);
        check_val("mrst_b", o_b, 32'd0);
        check_val("mrst_hold", 32'(o_alu_hold), 32'd0);
        check_val("mrst_ready", 32'(o_ready), 32'd1);
        @(posedge clk); #1;
        b0 = beats;
        issue(OP, 3'd0, 7'h00, 32'd1, 32'd1, 32'd0, 5'd7);
        drain();
        check_val("mrst_add_beats", 32'(beats - b0), 32'd1);

        // randomized traffic with random back-pressure
        rand_bp = 1'b1;
        for (int n = 0; n < 400; n++) begin
            rand_instr();
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
        rand_bp = 1'b0;
        @(posedge clk); #1;
        i_wb_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        check_val("final_queue", 32'(exp_rd.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
